// File: rtl/fir_seq_ctrl_if.sv
// fir_seq_ctrl_if -- handshake / RAM-port bundle for the FIR sequencer.
//   start, n_taps            : pass request and tap count minus one
//   cdc_addr_RAM, cdc_wr_RAM : register-decoder access to the coefficient RAM
//   ram_addr, ram_wr         : muxed coefficient RAM port
//   mac_clr, mac_en, mac_last: MAC accumulator control
//   busy, done, err_wr       : status
//   abort                    : only present when FIR_SEQ_ABORT_EN is defined
// Modports: master = requester / system side, slave = sequencer side.
interface fir_seq_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] n_taps;
  logic [ADDR_W-1:0] cdc_addr_RAM;
  logic              cdc_wr_RAM;
`ifdef FIR_SEQ_ABORT_EN
  logic              abort;
`endif
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic              mac_clr;
  logic              mac_en;
  logic              mac_last;
  logic              busy;
  logic              done;
  logic              err_wr;

  modport master (
`ifdef FIR_SEQ_ABORT_EN
    output abort,
`endif
    output start, n_taps, cdc_addr_RAM, cdc_wr_RAM,
    input  ram_addr, ram_wr, mac_clr, mac_en, mac_last, busy, done, err_wr
  );

  modport slave (
`ifdef FIR_SEQ_ABORT_EN
    input  abort,
`endif
    input  start, n_taps, cdc_addr_RAM, cdc_wr_RAM,
    output ram_addr, ram_wr, mac_clr, mac_en, mac_last, busy, done, err_wr
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl -- sequences one FIR pass over the coefficient RAM.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fir_seq_ctrl_if.slave (start/n_taps request, decoder RAM access,
//          RAM port, MAC controls, busy/done/err_wr status)
// Optional feature: define FIR_SEQ_ABORT_EN to add bus.abort, which drops
// an in-flight pass (CLR/RUN) back to IDLE without done or mac_last.
module fir_seq_ctrl #(
  parameter int ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  fir_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr;       // index of the tap being accumulated in RUN
  logic [ADDR_W-1:0] n_lat;     // tap count latched at start
  logic              err_wr_q;
  logic              err_set;
  logic              abort;
  logic              is_last;

  logic [ADDR_W-1:0] ram_addr_c;
  logic              ram_wr_c;
  logic              mac_clr_c, mac_en_c, mac_last_c, busy_c, done_c;

`ifdef FIR_SEQ_ABORT_EN
  assign abort = bus.abort;
`else
  assign abort = 1'b0;
`endif

  assign is_last = (ptr == n_lat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      n_lat    <= '0;
      err_wr_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.start) begin
        n_lat <= bus.n_taps;
        ptr   <= '0;
      end else if (state == RUN && !is_last) begin
        ptr <= ptr + ADDR_W'(1);
      end
      if (state == IDLE && bus.start)
        err_wr_q <= 1'b0;
      else if (err_set)
        err_wr_q <= 1'b1;
    end
  end

  // Address 0 is issued in CLR; each RUN cycle accumulates tap ptr while
  // issuing ptr+1, so the final RUN cycle issues nothing and holds n_lat
  // (no wrap when n_lat is all ones).
  always_comb begin
    state_n    = state;
    ram_addr_c = bus.cdc_addr_RAM;
    ram_wr_c   = 1'b0;
    mac_clr_c  = 1'b0;
    mac_en_c   = 1'b0;
    mac_last_c = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        ram_wr_c = bus.cdc_wr_RAM & ~rst;
        if (bus.start) state_n = CLR;
      end
      CLR: begin
        ram_addr_c = '0;
        mac_clr_c  = 1'b1;
        busy_c     = 1'b1;
        err_set    = bus.cdc_wr_RAM;
        state_n    = abort ? IDLE : RUN;
      end
      RUN: begin
        ram_addr_c = is_last ? n_lat : ptr + ADDR_W'(1);
        mac_en_c   = 1'b1;
        mac_last_c = is_last & ~abort;
        busy_c     = 1'b1;
        err_set    = bus.cdc_wr_RAM;
        if (abort)        state_n = IDLE;
        else if (is_last) state_n = DONE;
      end
      DONE: begin
        ram_addr_c = '0;
        done_c     = 1'b1;
        err_set    = bus.cdc_wr_RAM;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.ram_addr = ram_addr_c;
  assign bus.ram_wr   = ram_wr_c;
  assign bus.mac_clr  = mac_clr_c;
  assign bus.mac_en   = mac_en_c;
  assign bus.mac_last = mac_last_c;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.err_wr   = err_wr_q;

endmodule
